// File: rtl/fractal_colormap.sv
// Maps the free-running iteration stream through a writable RGB palette and
// emits an AXI4-Stream video stream; drops beats on overflow and realigns on frame start.
module fractal_colormap #(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  s_tdata,
  input  logic        s_tuser,
  input  logic        s_tlast,
  input  logic        s_tvalid,
  input  logic [7:0]  color_offset,
  input  logic        pal_we,
  input  logic [7:0]  pal_addr,
  input  logic [23:0] pal_wdata,
  output logic [23:0] m_tdata,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        overflow,
  input  logic        clear_overflow,
  output logic [15:0] drop_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = PW + 2;
  localparam int unsigned BW = 26;

  typedef enum logic {SYNC, PASS} state_t;

  state_t        state_q, state_d;
  logic [7:0]    offset_q, offset_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic          s1_v_q, s1_v_d;
  logic [7:0]    s1_addr_q, s1_addr_d;
  logic          s1_user_q, s1_user_d;
  logic          s1_last_q, s1_last_d;

  logic          s2_v_q, s2_v_d;
  logic          s2_user_q, s2_user_d;
  logic          s2_last_q, s2_last_d;
  logic [23:0]   s2_data_q;

  logic [BW-1:0] ring_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] ring_cnt_q, ring_cnt_d;

  logic          m_tvalid_q, m_tvalid_d;
  logic [BW-1:0] m_beat_q, m_beat_d;

  logic [23:0]   palette [256];

  logic [OW-1:0] occ;
  logic          space, accept, drop, lack;
  logic [7:0]    eff_off;
  logic          pop, load, ring_we, ring_re;
  logic [BW-1:0] s2_beat;
  logic [CW-1:0] fifo_cnt;

  assign s2_beat  = {s2_user_q, s2_last_q, s2_data_q};
  assign fifo_cnt = ring_cnt_q + CW'(m_tvalid_q);

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    s1_v_d     = 1'b0;
    s1_addr_d  = s1_addr_q;
    s1_user_d  = s_tuser;
    s1_last_d  = s_tlast;
    s2_v_d     = s1_v_q;
    s2_user_d  = s1_user_q;
    s2_last_d  = s1_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ring_cnt_d = ring_cnt_q;
    m_tvalid_d = m_tvalid_q;
    m_beat_d   = m_beat_q;
    accept     = 1'b0;
    drop       = 1'b0;
    lack       = 1'b0;
    ring_we    = 1'b0;
    ring_re    = 1'b0;

    // Admission: in-flight pipeline beats count against FIFO space.
    occ   = OW'(ring_cnt_q) + OW'(m_tvalid_q) + OW'(s1_v_q) + OW'(s2_v_q);
    space = occ < OW'(FIFO_DEPTH);
    if (s_tvalid) begin
      case (state_q)
        SYNC: begin
          if (s_tuser && space) begin
            accept  = 1'b1;
            state_d = PASS;
          end else begin
            drop = 1'b1;
            lack = !space;
          end
        end
        default: begin
          if (space) begin
            accept = 1'b1;
          end else begin
            drop    = 1'b1;
            lack    = 1'b1;
            state_d = SYNC;
          end
        end
      endcase
    end

    eff_off  = (accept && s_tuser) ? color_offset : offset_q;
    offset_d = eff_off;
    s1_v_d   = accept;
    if (accept) begin
      s1_addr_d = (s_tdata == 8'hFF) ? 8'hFF : s_tdata + eff_off;
    end

    // A drop in the same cycle as a clear leaves the fresh drop recorded.
    if (clear_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end
    if (drop) begin
      if (lack) begin
        overflow_d = 1'b1;
      end
      if (drop_cnt_d != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_d + 16'd1;
      end
    end

    // Output register is the FIFO head; the ring holds the entries behind it.
    pop  = m_tvalid_q && m_tready;
    load = !m_tvalid_q || pop;
    if (load) begin
      if (ring_cnt_q != CW'(0)) begin
        ring_re    = 1'b1;
        m_beat_d   = ring_q[rd_ptr_q];
        m_tvalid_d = 1'b1;
        ring_we    = s2_v_q;
      end else if (s2_v_q) begin
        m_beat_d   = s2_beat;
        m_tvalid_d = 1'b1;
      end else begin
        m_tvalid_d = 1'b0;
      end
    end else begin
      ring_we = s2_v_q;
    end
    wr_ptr_d   = wr_ptr_q + PW'(ring_we);
    rd_ptr_d   = rd_ptr_q + PW'(ring_re);
    ring_cnt_d = ring_cnt_q + CW'(ring_we) - CW'(ring_re);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= SYNC;
      offset_q   <= 8'd0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
      s1_v_q     <= 1'b0;
      s1_addr_q  <= 8'd0;
      s1_user_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_user_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ring_cnt_q <= '0;
      m_tvalid_q <= 1'b0;
      m_beat_q   <= '0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      s1_v_q     <= s1_v_d;
      s1_addr_q  <= s1_addr_d;
      s1_user_q  <= s1_user_d;
      s1_last_q  <= s1_last_d;
      s2_v_q     <= s2_v_d;
      s2_user_q  <= s2_user_d;
      s2_last_q  <= s2_last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ring_cnt_q <= ring_cnt_d;
      m_tvalid_q <= m_tvalid_d;
      m_beat_q   <= m_beat_d;
    end
  end

  // Palette and ring storage are plain memories; the palette read is read-first.
  always_ff @(posedge clk) begin
    if (pal_we) begin
      palette[pal_addr] <= pal_wdata;
    end
    s2_data_q <= palette[s1_addr_q];
    if (ring_we) begin
      ring_q[wr_ptr_q] <= s2_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      a_no_fifo_overrun: assert (!(s2_v_q && (fifo_cnt == CW'(FIFO_DEPTH)) && !pop));
    end
  end

  assign m_tdata    = m_beat_q[23:0];
  assign m_tlast    = m_beat_q[24];
  assign m_tuser    = m_beat_q[25];
  assign m_tvalid   = m_tvalid_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: doc/fractal_colormap.md
# fractal_colormap

Downstream stage of the fractal generator. It takes the generator's free-running 8-bit iteration stream, which has no backpressure, and maps each value through a writable 256-entry RGB palette with optional palette cycling. The result is emitted as a 24-bit AXI4-Stream video stream with full tready handshake, buffered by an internal FIFO. On overflow the block drops beats and resynchronises on the next frame start, so downstream never sees a partial or misaligned frame.

## Interface
- FIFO_DEPTH, 16: output FIFO entries; power of two, at least 4.
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- s_tdata  in  8  iteration count.
- s_tuser  in  1  frame start.
- s_tlast  in  1  line end.
- s_tvalid  in  1  beat valid; no s_tready exists.
- color_offset  in  8  palette rotation; sampled only on an accepted frame-start beat.
- pal_we  in  1  palette write strobe.
- pal_addr  in  8  palette write address.
- pal_wdata  in  24  palette entry, {R,G,B}.
- m_tdata  out  24  RGB pixel.
- m_tuser  out  1  frame start.
- m_tlast  out  1  line end.
- m_tvalid  out  1  output valid.
- m_tready  in  1  downstream ready.
- overflow  out  1  sticky; set whenever a beat is dropped for lack of space.
- clear_overflow  in  1  one-cycle pulse that clears `overflow`.
- drop_count  out  16  number of dropped beats; saturates at 16'hFFFF; cleared by `clear_overflow`.

## Operation
- **Admission state machine** (evaluated only on cycles where s_tvalid=1):
  - States are SYNC (reset state) and PASS.
  - Occupancy = FIFO entries + valid pipeline stages (S1, S2), sampled at the start of the cycle. A pop in the same cycle is not credited.
  - "Space" means occupancy < FIFO_DEPTH.
- **SYNC:**
  - A beat with s_tuser=1 and space is accepted, and the state moves to PASS.
  - Any other beat is discarded and counted in drop_count. It does not set overflow unless space was lacking.
- **PASS:**
  - A beat with space is accepted.
  - A beat without space is dropped: overflow is set, drop_count increments, and the state moves to SYNC.
- **Offset register:**
  - Resets to 0.
  - Loads color_offset when a beat with s_tuser=1 is accepted.
  - That frame-start beat already uses the new value.
- **Palette address:**
  - Address = s_tdata + offset (mod 256).
  - Exception: s_tdata=8'hFF, the interior / max-iteration value, always addresses entry 255 regardless of offset.
- **Palette memory:**
  - 256x24 block RAM, not reset.
  - Write port is independent of the lookup path.
  - A same-cycle read and write to the same address returns the old data (read-first).
- **Sideband:** s_tuser and s_tlast travel alongside the data unchanged.
- **FIFO:**
  - First-word-fall-through, with registered outputs.
  - Pop occurs when m_tvalid and m_tready are both 1.
  - The admission rule guarantees the FIFO never overflows. Write-while-full is an assertion failure.
- **clear_overflow:** clears overflow and drop_count. If a drop happens in the same cycle, the drop wins: overflow=1 and drop_count=1.
- **Reset mid-operation:**
  - FIFO and pipeline are flushed, m_tvalid drops the next cycle, and the state returns to SYNC.
  - Palette contents are retained.

## Timing
- **Pipeline:**
  - S1 registers address and sideband at cycle t+1 for an input beat at cycle t.
  - S2 is the RAM output register at t+2.
  - FIFO write happens at the end of t+2.
  - m_tvalid=1 at t+3 when the FIFO was empty.
- **Throughput:** minimum latency is 3 cycles, and throughput is 1 beat/cycle while m_tready=1.
- **Reset values:** m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, overflow=0, drop_count=0, offset=0, state=SYNC.
- **Handshake rules:**
  - m_tdata, m_tuser and m_tlast hold stable while m_tvalid=1 and m_tready=0.
  - m_tvalid never deasserts without a pop.
- **Palette write visibility:** a write at cycle w is visible to a lookup whose S1 occurs at cycle w+1 or later.
- **Output ordering:** beat order is preserved, and dropped beats leave no gap markers.

## Test plan
- **Basic mapping:** palette[i]={i,~i,8'h55}, offset 0, m_tready=1. Send a 4x2 frame with values 0..7, tuser on the first beat and tlast on beats 3 and 7. Required: outputs {0,FF,55}..{7,F8,55} arrive 3 cycles after each input, with tuser/tlast on the same beats.
- **Offset:**
  - color_offset=8'h10 with frame values 0, 8'hF5, 8'hFF. Required: addresses 8'h10, 8'h05, 8'hFF.
  - Changing color_offset mid-frame has no effect until the next tuser.
- **Backpressure hold:** with FIFO_DEPTH=16, hold m_tready=0 for 10 cycles mid-line. Required: no drops, m_tdata held stable, all beats delivered in order after release.
- **Overflow:**
  - Hold m_tready=0 for 40 cycles during a 64-pixel frame. Required: exactly 16 beats are accepted.
  - Beat 17 sets overflow. Remaining beats up to the next tuser are dropped, with drop_count equal to 48.
  - The next frame is output complete, starting with tuser.
- **Startup alignment:** release reset mid-frame. Required: no output until the first tuser beat. Pre-tuser beats are counted in drop_count, and overflow stays 0.
- **Palette write collision:** write palette[5]=24'hABCDEF in the same cycle that value 5 is looked up. Required: the old entry is output for that beat, and 24'hABCDEF is output for a lookup one cycle later.
